// File: rtl/cga_text_fetch.sv
// cga_text_fetch
//   Text-mode character fetch and pixel serialiser for a CGA-style display.
//   For each character cell it reads the character and attribute bytes from
//   VRAM, looks up the glyph row in a synchronous font ROM, and shifts the row
//   out as 4-bit IRGB pixels one cell later. The pixels include attribute
//   colours, blink or bright-background handling, and the cursor.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   dot_en              pixel shift enable (every clk 80-col, every 2nd 40-col)
//   char_start          one-clk pulse at the start of each character cell
//   ma, ra              CRTC word address / glyph row, sampled on char_start
//   disp_en_in          CRTC display enable, sampled on char_start
//   cursor_in           cursor active for the cell, sampled on char_start
//   blink_en            1: attr[7] selects blink, 0: attr[7] is background intensity
//   blink_phase         slow blink toggle
//   pixel_addr/read     VRAM read port (data returns combinationally)
//   pixel_data          VRAM read data
//   font_addr           font ROM address {char, ra}
//   font_data           font ROM data, one clk after font_addr
//   pix_color           IRGB pixel out
//   fetch_overrun       sticky flag: char_start arrived mid-fetch
//
// State | meaning
//   IDLE  | waiting for char_start
//   CHAR  | VRAM read of the character byte (even address)
//   ATTR  | VRAM read of the attribute byte (odd address)
//   FONT  | font ROM address presented
//   FWAIT | font data returns; fetch results move to staging

module cga_text_fetch #(
  parameter logic [18:0] BASE_ADDR = 19'h38000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dot_en,
  input  logic        char_start,
  input  logic [12:0] ma,
  input  logic [2:0]  ra,
  input  logic        disp_en_in,
  input  logic        cursor_in,
  input  logic        blink_en,
  input  logic        blink_phase,
  output logic [18:0] pixel_addr,
  output logic        pixel_read,
  input  logic [7:0]  pixel_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  pix_color,
  output logic        fetch_overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHAR  = 3'd1,
    ATTR  = 3'd2,
    FONT  = 3'd3,
    FWAIT = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // fetch registers (current cell being fetched)
  logic [12:0] f_ma;
  logic [2:0]  f_ra;
  logic        f_de;
  logic        f_cursor;
  logic [7:0]  f_char;
  logic [7:0]  f_attr;

  // staging (last completed fetch)
  logic [7:0]  stg_font;
  logic [7:0]  stg_attr;
  logic        stg_de;
  logic        stg_cursor;

  // display registers (cell currently on screen)
  logic [7:0]  shifter;
  logic [7:0]  d_attr;
  logic        d_de;
  logic        d_cursor;

  logic [3:0]  fg_raw;
  logic [3:0]  fg;
  logic [3:0]  bg;
  logic        blink_off;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // A char_start in any state (re)starts the fetch in CHAR; outside IDLE
  // this aborts the in-flight fetch.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      CHAR:    state_next = ATTR;
      ATTR:    state_next = FONT;
      FONT:    state_next = FWAIT;
      FWAIT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (char_start) begin
      state_next = CHAR;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // BASE_ADDR is combined by OR so the 13-bit word address wraps inside the
  // 16 KB page instead of carrying into higher address bits.
  // ---------------------------------------------------------------------
  always_comb begin
    pixel_read = 1'b0;
    pixel_addr = 19'd0;
    font_addr  = 11'd0;
    case (state)
      CHAR: begin
        pixel_read = 1'b1;
        pixel_addr = BASE_ADDR | {5'b0, f_ma, 1'b0};
      end
      ATTR: begin
        pixel_read = 1'b1;
        pixel_addr = BASE_ADDR | {5'b0, f_ma, 1'b1};
      end
      FONT: begin
        font_addr = {f_char, f_ra};
      end
      default: begin
        pixel_read = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Fetch registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      f_ma     <= 13'd0;
      f_ra     <= 3'd0;
      f_de     <= 1'b0;
      f_cursor <= 1'b0;
      f_char   <= 8'd0;
      f_attr   <= 8'd0;
    end else begin
      if (char_start) begin
        f_ma     <= ma;
        f_ra     <= ra;
        f_de     <= disp_en_in;
        f_cursor <= cursor_in;
      end
      // snow bytes (0xFF) are taken as-is
      if (state == CHAR) begin
        f_char <= pixel_data;
      end
      if (state == ATTR) begin
        f_attr <= pixel_data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Staging: written only when a fetch completes undisturbed. A char_start
  // on the FWAIT edge aborts the fetch, so staging keeps the previous cell.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stg_font   <= 8'd0;
      stg_attr   <= 8'd0;
      stg_de     <= 1'b0;
      stg_cursor <= 1'b0;
    end else if ((state == FWAIT) && !char_start) begin
      stg_font   <= font_data;
      stg_attr   <= f_attr;
      stg_de     <= f_de;
      stg_cursor <= f_cursor;
    end
  end

  // ---------------------------------------------------------------------
  // Overrun flag (sticky until reset)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_overrun <= 1'b0;
    end else if (char_start && (state != IDLE)) begin
      fetch_overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Display registers and pixel shifter; char_start wins over dot_en.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shifter  <= 8'd0;
      d_attr   <= 8'd0;
      d_de     <= 1'b0;
      d_cursor <= 1'b0;
    end else if (char_start) begin
      shifter  <= stg_font;
      d_attr   <= stg_attr;
      d_de     <= stg_de;
      d_cursor <= stg_cursor;
    end else if (dot_en) begin
      shifter  <= {shifter[6:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------
  // Pixel colour
  // ---------------------------------------------------------------------
  always_comb begin
    fg_raw    = d_attr[3:0];
    bg        = blink_en ? {1'b0, d_attr[6:4]} : d_attr[7:4];
    blink_off = blink_en & d_attr[7] & ~blink_phase;
    fg        = blink_off ? bg : fg_raw;
    if (!d_de) begin
      pix_color = 4'h0;
    end else if (d_cursor) begin
      pix_color = fg;
    end else if (shifter[7]) begin
      pix_color = fg;
    end else begin
      pix_color = bg;
    end
  end

endmodule

// File: tb/tb_cga_text_fetch.sv
module tb_cga_text_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dot_en;
  logic        char_start;
  logic [12:0] ma;
  logic [2:0]  ra;
  logic        disp_en_in;
  logic        cursor_in;
  logic        blink_en;
  logic        blink_phase;
  logic [18:0] pixel_addr;
  logic        pixel_read;
  logic [7:0]  pixel_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [3:0]  pix_color;
  logic        fetch_overrun;

  logic        snow;
  logic [7:0]  vram [0:524287];
  logic [7:0]  rom  [0:2047];

  int errors = 0;
  int checks = 0;

  logic [18:0] addr_q[$];
  logic [10:0] font_q[$];
  logic [3:0]  pix_q[$];
  logic [3:0]  disp_pix[$];
  logic        prev_odd = 1'b0;

  always #5 clk = ~clk;

  cga_text_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dot_en        (dot_en),
    .char_start    (char_start),
    .ma            (ma),
    .ra            (ra),
    .disp_en_in    (disp_en_in),
    .cursor_in     (cursor_in),
    .blink_en      (blink_en),
    .blink_phase   (blink_phase),
    .pixel_addr    (pixel_addr),
    .pixel_read    (pixel_read),
    .pixel_data    (pixel_data),
    .font_addr     (font_addr),
    .font_data     (font_data),
    .pix_color     (pix_color),
    .fetch_overrun (fetch_overrun)
  );

  // VRAM: combinational read, snow forces 0xFF. Font ROM: synchronous.
  assign pixel_data = snow ? 8'hFF : vram[pixel_addr];
  always @(posedge clk) font_data <= rom[font_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the DUT presents a read, a font lookup, or a pixel.
  always @(negedge clk) begin
    if (pixel_read) begin
      if (addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got addr %0h expected no read", pixel_addr);
      end else begin
        chk("pixel_addr", pixel_addr, addr_q.pop_front());
      end
    end else begin
      chk("pixel_addr_idle", pixel_addr, 0);
    end
    if (prev_odd) begin
      if (font_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_font: got %0h expected no lookup", font_addr);
      end else begin
        chk("font_addr", font_addr, font_q.pop_front());
      end
    end
    prev_odd <= pixel_read && pixel_addr[0];
    if (pix_q.size() > 0) chk("pix_color", pix_color, pix_q.pop_front());
  end

  // Pixels displayed in the next cell: nibbles of s, MSB first, each held rep clk.
  task automatic push_seq(input logic [31:0] s, input int rep, input int n);
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      v = s >> (28 - 4 * (i / rep));
      disp_pix.push_back(v[3:0]);
    end
  endtask

  task automatic run_cell(input logic [12:0] m, input logic [2:0] r, input logic de,
                          input logic cur, input logic snw, input logic be, input logic bp,
                          input logic c40, input int len, input logic [18:0] a0,
                          input logic [18:0] a1, input logic [10:0] fa);
    addr_q.push_back(a0);
    addr_q.push_back(a1);
    font_q.push_back(fa);
    ma = m;
    ra = r;
    disp_en_in = de;
    cursor_in = cur;
    char_start = 1'b1;
    dot_en = 1'b1;
    @(posedge clk);
    #1;
    char_start = 1'b0;
    blink_en = be;
    blink_phase = bp;
    snow = snw;
    while (disp_pix.size() > 0) pix_q.push_back(disp_pix.pop_front());
    for (int k = 1; k < len; k++) begin
      dot_en = c40 ? ((k % 2) == 0) : 1'b1;
      @(posedge clk);
      #1;
      snow = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 524288; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    vram[19'h38020] = 8'h41; vram[19'h38021] = 8'h1E; rom[11'h20B] = 8'hA5;
    vram[19'h3BFFE] = 8'h42; vram[19'h3BFFF] = 8'h9C; rom[11'h210] = 8'hFF;
    vram[19'h38040] = 8'h43; vram[19'h38041] = 8'h9C; rom[11'h219] = 8'h00;
    vram[19'h38060] = 8'h44; vram[19'h38061] = 8'h07; rom[11'h222] = 8'h00;
    vram[19'h38080] = 8'h41; vram[19'h38081] = 8'h1E;
    vram[19'h380A0] = 8'h41; vram[19'h380A1] = 8'h2A; rom[11'h7FD] = 8'hF0;
    vram[19'h380C0] = 8'h46; vram[19'h380C1] = 8'h4F; rom[11'h234] = 8'h3C;

    reset_n = 1'b0; dot_en = 1'b1; char_start = 1'b0; ma = '0; ra = '0;
    disp_en_in = 1'b0; cursor_in = 1'b0; blink_en = 1'b0; blink_phase = 1'b1; snow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pix_color", pix_color, 0);
    chk("rst_pixel_read", pixel_read, 0);
    chk("rst_pixel_addr", pixel_addr, 0);
    chk("rst_font_addr", font_addr, 0);
    chk("rst_overrun", fetch_overrun, 0);
    reset_n = 1'b1;

    // single cell; first cell after reset shows cleared staging
    push_seq(32'h00000000, 1, 8);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 0, 8, 19'h38020, 19'h38021, 11'h20B);
    // address wrap; display A5 / 1E
    push_seq(32'hE1E11E1E, 1, 8);
    run_cell(13'h1FFF, 3'd0, 1, 0, 0, 0, 1, 0, 8, 19'h3BFFE, 19'h3BFFF, 11'h210);
    // blink on, phase 1
    push_seq(32'hCCCCCCCC, 1, 8);
    run_cell(13'h1FFF, 3'd0, 1, 0, 0, 1, 1, 0, 8, 19'h3BFFE, 19'h3BFFF, 11'h210);
    // blink on, phase 0 -> fg shows bg
    push_seq(32'h11111111, 1, 8);
    run_cell(13'h0020, 3'd1, 1, 0, 0, 1, 0, 0, 8, 19'h38040, 19'h38041, 11'h219);
    // bright background
    push_seq(32'h99999999, 1, 8);
    run_cell(13'h0030, 3'd2, 1, 1, 0, 0, 1, 0, 8, 19'h38060, 19'h38061, 11'h222);
    // cursor cell
    push_seq(32'h77777777, 1, 8);
    run_cell(13'h0040, 3'd3, 0, 0, 0, 0, 1, 0, 8, 19'h38080, 19'h38081, 11'h20B);
    // display disabled cell; snow fetch
    push_seq(32'h00000000, 1, 8);
    run_cell(13'h0050, 3'd5, 1, 0, 1, 0, 1, 0, 8, 19'h380A0, 19'h380A1, 11'h7FD);
    // 40-column display of snow cell (F0 / 2A)
    push_seq(32'hAAAA2222, 2, 16);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 1, 16, 19'h38020, 19'h38021, 11'h20B);
    // minimum legal spacing: 5 clk
    push_seq(32'hE1E11E1E, 1, 5);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 0, 5, 19'h38020, 19'h38021, 11'h20B);
    chk("overrun_after_5clk", fetch_overrun, 0);
    // 4 clk spacing: char_start on the FWAIT edge
    push_seq(32'hE1E11E1E, 1, 4);
    run_cell(13'h0020, 3'd1, 1, 0, 0, 0, 1, 0, 4, 19'h38040, 19'h38041, 11'h219);
    chk("overrun_before_4clk", fetch_overrun, 0);
    // stale staging (A5/1E) shown again
    push_seq(32'hE1E11E1E, 1, 8);
    run_cell(13'h0030, 3'd2, 1, 1, 0, 0, 1, 0, 8, 19'h38060, 19'h38061, 11'h222);
    chk("overrun_fwait_edge", fetch_overrun, 1);

    // one-edge reset clears flag and display
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst2_overrun", fetch_overrun, 0);
    chk("rst2_pix_color", pix_color, 0);
    chk("rst2_pixel_read", pixel_read, 0);

    // overrun with 3 clk spacing; aborted fetch must not reach staging
    push_seq(32'h00000000, 1, 3);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 0, 3, 19'h38020, 19'h38021, 11'h20B);
    chk("overrun_before_3clk", fetch_overrun, 0);
    push_seq(32'h00000000, 1, 8);
    run_cell(13'h0060, 3'd4, 1, 0, 0, 0, 1, 0, 8, 19'h380C0, 19'h380C1, 11'h234);
    chk("overrun_3clk", fetch_overrun, 1);
    push_seq(32'h44FFFF44, 1, 8);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 0, 8, 19'h38020, 19'h38021, 11'h20B);
    chk("overrun_sticky", fetch_overrun, 1);
    push_seq(32'hE1E11E1E, 1, 8);
    run_cell(13'h0010, 3'd3, 1, 0, 0, 0, 1, 0, 8, 19'h38020, 19'h38021, 11'h20B);
    repeat (8) @(posedge clk);
    #1;
    chk("overrun_sticky_end", fetch_overrun, 1);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("font_q_drained", font_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
